// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - I-cache / D-cache arbiter for a shared physical-memory line port
//
// Purpose:
//   Grants the single downstream line port to one cache at a time, latches the
//   winner's command for the whole transaction and steers the completion back
//   to the granted side only. The D side wins ties unless the I side has
//   already been passed over MAX_D_STREAK times in a row.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   i_pmem_*              I-cache miss port (read only)
//   d_pmem_*              D-cache miss port (read or writeback)
//   pmem_*                shared downstream port; command is registered, resp is a pulse
//   grant_i, grant_d      which side currently owns the downstream port
module cache_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int LINE_WIDTH   = 128,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic                  grant_i,
  output logic                  grant_d
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    HOLD    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [SW-1:0]         streak_q, streak_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;

  logic d_req;
  logic i_starved;
  logic serving;

  assign d_req     = d_pmem_read | d_pmem_write;
  // I has waited through the maximum run of D grants and must win the next tie.
  assign i_starved = i_pmem_read && (streak_q == STREAK_MAX);

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;

    case (state_q)
      IDLE: begin
        if (d_req && !i_starved) begin
          state_d = SERVE_D;
          addr_d  = d_pmem_address;
          wdata_d = d_pmem_wdata;
          write_d = d_pmem_write;
          // The streak only measures D grants that overtook a waiting I request.
          if (i_pmem_read) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
          end else begin
            streak_d = '0;
          end
        end else if (i_pmem_read) begin
          state_d  = SERVE_I;
          addr_d   = i_pmem_address;
          wdata_d  = '0;
          write_d  = 1'b0;
          streak_d = '0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Dead cycle so the finished requester can drop its level request
        // before IDLE samples it again.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      streak_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
    end
  end

  assign grant_i = (state_q == SERVE_I);
  assign grant_d = (state_q == SERVE_D);
  assign serving = grant_i | grant_d;

  assign pmem_read    = serving & ~write_q;
  assign pmem_write   = serving & write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // Completion goes only to the owner; a stray pulse outside a grant is dropped.
  assign i_pmem_resp  = pmem_resp & grant_i;
  assign d_pmem_resp  = pmem_resp & grant_d;

  // Both consumers see the raw line and qualify it with their own resp.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - scoreboard bench for cache_arbiter
module tb_cache_arbiter;

  localparam int AW  = 16;
  localparam int LW  = 128;
  localparam int MAX = 4;

  logic          clk;
  logic          reset;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic          grant_i;
  logic          grant_d;

  logic mem_resp;
  logic dir_resp;
  assign pmem_resp = mem_resp | dir_resp;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MAX_D_STREAK(MAX)) dut (
    .clk(clk), .reset(reset),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .grant_i(grant_i), .grant_d(grant_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
    logic [LW-1:0] wdata;
  } txn_t;

  txn_t iq[$];
  txn_t dq[$];

  int n_cmp  = 0;
  int n_fail = 0;

  logic chk_en   = 1'b0;
  logic mem_auto = 1'b0;
  logic snap_i   = 1'b0;
  logic snap_d   = 1'b0;

  // Reference model state: run of D grants that overtook a waiting I request,
  // which side owns the port, and whether this cycle must be the quiet turnaround.
  int streak_m    = 0;
  int active_m    = 0;
  logic quiet_m   = 1'b0;
  int starve_hits = 0;

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    return {a, ~a, a ^ 16'h5A5A, a + 16'h1111, ~a ^ 16'h00FF, a - 16'h0101,
            a[7:0], a[15:8], 16'hBEEF};
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  // Downstream memory: fixed line contents per address, random 0..3 extra cycles.
  initial begin
    mem_resp   = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (mem_auto && (pmem_read || pmem_write)) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #2;
        end
        pmem_rdata = pmem_read ? line_of(pmem_address)
                               : {$urandom, $urandom, $urandom, $urandom};
        mem_resp = 1'b1;
        @(posedge clk); #2;
        mem_resp   = 1'b0;
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // Request levels as the arbiter sees them at the deciding edge.
  always @(posedge clk) begin
    snap_i = i_pmem_read;
    snap_d = d_pmem_read | d_pmem_write;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (chk_en) begin
      txn_t e;
      logic exp_d;
      check("one_grant", 128'(grant_i & grant_d), 128'(0));
      if (quiet_m) begin
        check("hold_quiet", 128'({grant_i, grant_d, pmem_read, pmem_write}), 128'(0));
        quiet_m = 1'b0;
      end else if (active_m == 0 && (grant_i || grant_d)) begin
        check("grant_has_req", 128'(snap_i | snap_d), 128'(1));
        exp_d = snap_d && !(snap_i && streak_m == MAX);
        check("arb_winner", 128'(grant_d), 128'(exp_d));
        if (grant_i && snap_d && streak_m == MAX) starve_hits++;
        if (grant_d) begin
          streak_m = snap_i ? ((streak_m < MAX) ? streak_m + 1 : MAX) : 0;
          active_m = 2;
        end else begin
          streak_m = 0;
          active_m = 1;
        end
      end else begin
        check("grant_i_hold", 128'(grant_i), 128'(active_m == 1));
        check("grant_d_hold", 128'(grant_d), 128'(active_m == 2));
      end

      if (active_m == 0) begin
        check("idle_cmd", 128'({pmem_read, pmem_write}), 128'(0));
      end else if (active_m == 1) begin
        if (iq.size() == 0) fail_now("i_queue_empty");
        else begin
          e = iq[0];
          check("i_addr", 128'(pmem_address), 128'(e.addr));
          check("i_cmd", 128'({pmem_read, pmem_write}), 128'(2'b10));
        end
      end else begin
        if (dq.size() == 0) fail_now("d_queue_empty");
        else begin
          e = dq[0];
          check("d_addr", 128'(pmem_address), 128'(e.addr));
          check("d_cmd", 128'({pmem_read, pmem_write}), 128'({~e.write, e.write}));
          if (e.write) check("d_wdata", pmem_wdata, e.wdata);
        end
      end

      check("i_resp_fwd", 128'(i_pmem_resp), 128'(pmem_resp && active_m == 1));
      check("d_resp_fwd", 128'(d_pmem_resp), 128'(pmem_resp && active_m == 2));

      if (pmem_resp && active_m == 1 && iq.size() != 0) begin
        e = iq.pop_front();
        check("i_rdata", i_pmem_rdata, line_of(e.addr));
      end
      if (pmem_resp && active_m == 2 && dq.size() != 0) begin
        e = dq.pop_front();
        if (!e.write) check("d_rdata", d_pmem_rdata, line_of(e.addr));
      end
      if (pmem_resp && active_m != 0) begin
        active_m = 0;
        quiet_m  = 1'b1;
      end
    end
  end

  task automatic run_i(input int n, input int maxgap);
    for (int k = 0; k < n; k++) begin
      txn_t t;
      int   waited;
      logic got;
      t.addr  = {2'b00, 10'($urandom), 4'h0};
      t.write = 1'b0;
      t.wdata = '0;
      iq.push_back(t);
      i_pmem_address = t.addr;
      i_pmem_read    = 1'b1;
      waited = 0;
      got    = 1'b0;
      while (!got && waited < 300) begin
        @(negedge clk);
        if (i_pmem_resp) got = 1'b1;
        else begin
          if (grant_i) i_pmem_address = 16'($urandom);
          waited++;
        end
      end
      if (!got) fail_now("i_wait");
      @(posedge clk); #1;
      i_pmem_read = 1'b0;
      @(posedge clk); #1;
      repeat ($urandom_range(0, maxgap)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic run_d(input int n, input int maxgap);
    for (int k = 0; k < n; k++) begin
      txn_t t;
      int   waited;
      logic got;
      t.write = 1'($urandom);
      t.addr  = {1'b1, 11'($urandom), 4'h0};
      if (!t.write) t.addr[15:14] = 2'b01;
      t.wdata = {$urandom, $urandom, $urandom, $urandom};
      dq.push_back(t);
      d_pmem_address = t.addr;
      d_pmem_wdata   = t.wdata;
      d_pmem_read    = ~t.write;
      d_pmem_write   = t.write;
      waited = 0;
      got    = 1'b0;
      while (!got && waited < 300) begin
        @(negedge clk);
        if (d_pmem_resp) got = 1'b1;
        else begin
          if (grant_d) begin
            d_pmem_address = 16'($urandom);
            d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
          end
          waited++;
        end
      end
      if (!got) fail_now("d_wait");
      @(posedge clk); #1;
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
      @(posedge clk); #1;
      repeat ($urandom_range(0, maxgap)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dir_resp       = 1'b0;
    reset          = 1'b1;
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h1230;
    d_pmem_read    = 1'b1;
    d_pmem_write   = 1'b0;
    d_pmem_address = 16'h8000;
    d_pmem_wdata   = {16{8'hA5}};

    // Reset with both requests pending: everything quiet.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd", 128'({pmem_read, pmem_write}), 128'(0));
    check("rst_grant", 128'({grant_i, grant_d}), 128'(0));
    check("rst_resp", 128'({i_pmem_resp, d_pmem_resp}), 128'(0));
    check("rst_addr", 128'(pmem_address), 128'(0));
    check("rst_wdata", pmem_wdata, 128'(0));
    reset = 1'b0;

    // First edge after release: D wins the tie.
    @(negedge clk);
    check("first_grant", 128'({grant_i, grant_d}), 128'(2'b01));
    check("first_addr", 128'(pmem_address), 128'(16'h8000));
    check("first_cmd", 128'({pmem_read, pmem_write}), 128'(2'b10));

    // Abandon it, then let I win alone.
    reset       = 1'b1;
    d_pmem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("i_grant", 128'({grant_i, grant_d}), 128'(2'b10));
    check("i_addr_dir", 128'(pmem_address), 128'(16'h1230));

    // Reset mid-SERVE_I, then a late resp must be ignored.
    reset = 1'b1;
    @(posedge clk); #1;
    dir_resp = 1'b1;
    @(negedge clk);
    check("late_resp_i", 128'(i_pmem_resp), 128'(0));
    check("late_cmd", 128'({pmem_read, pmem_write, grant_i}), 128'(0));
    reset       = 1'b0;
    i_pmem_read = 1'b0;
    @(negedge clk);
    check("stray_resp", 128'({i_pmem_resp, d_pmem_resp, grant_i, grant_d}), 128'(0));
    dir_resp = 1'b0;
    @(negedge clk);

    // Randomized traffic checked by the scoreboard.
    streak_m = 0;
    active_m = 0;
    quiet_m  = 1'b0;
    mem_auto = 1'b1;
    chk_en   = 1'b1;
    fork
      run_i(30, 3);
      run_d(30, 3);
    join
    // Back-to-back traffic from both sides to exercise the starvation bound.
    fork
      run_i(8, 0);
      run_d(30, 0);
    join
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("starve_bound_hit", 128'(starve_hits > 0), 128'(1));
    check("queues_drained", 128'(iq.size() + dq.size()), 128'(0));
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares one physical-memory / L2 line port between the I-cache (IF-stage misses) and the D-cache (MEM-stage misses, fed from the EX/MEM pipeline register).
- Grants one requester at a time and latches its command for the whole transaction.
- Returns the downstream response only to the granted side.
- D-side has priority, bounded by an anti-starvation limit for instruction fetch.

Parameters:
ADDR_WIDTH, 16, byte address width (lc3b_word)
LINE_WIDTH, 128, cache line width in bits
MAX_D_STREAK, 4, consecutive D grants allowed while an I request waits (>=1)

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
i_pmem_read  in  1  I-cache line read request, level, held until i_pmem_resp
i_pmem_address  in  ADDR_WIDTH  I-cache line address
i_pmem_rdata  out  LINE_WIDTH  read line to I-cache
i_pmem_resp  out  1  transaction done, I side
d_pmem_read  in  1  D-cache line read request
d_pmem_write  in  1  D-cache writeback request (never together with d_pmem_read)
d_pmem_address  in  ADDR_WIDTH  D-cache line address
d_pmem_wdata  in  LINE_WIDTH  writeback line
d_pmem_rdata  out  LINE_WIDTH  read line to D-cache
d_pmem_resp  out  1  transaction done, D side
pmem_read  out  1  downstream read
pmem_write  out  1  downstream write
pmem_address  out  ADDR_WIDTH  downstream address (latched)
pmem_wdata  out  LINE_WIDTH  downstream write data (latched)
pmem_rdata  in  LINE_WIDTH  downstream read data, valid with pmem_resp
pmem_resp  in  1  downstream completion, one-cycle pulse
grant_i  out  1  state == SERVE_I
grant_d  out  1  state == SERVE_D

Behaviour:
- **States:** IDLE, SERVE_I, SERVE_D, HOLD (one-cycle turnaround).
- **Reset:** next state IDLE, streak counter 0, latched address/wdata/op cleared to 0. All outputs 0: pmem_read, pmem_write, pmem_address, pmem_wdata, both resp signals, both grants. i_pmem_rdata and d_pmem_rdata are passthroughs of pmem_rdata.
- **IDLE, no request:** stay in IDLE.
- **IDLE, D only:** go to SERVE_D.
- **IDLE, I only:** go to SERVE_I.
- **IDLE, both pending:** go to SERVE_D unless streak == MAX_D_STREAK, in which case go to SERVE_I.
- **Latching on grant:** address, wdata and op (read/write) of the winner are registered on the IDLE->SERVE edge. Requester input changes after that point are ignored.
- **Streak counter:**
  - Increments on a D grant made while i_pmem_read = 1; saturates at MAX_D_STREAK.
  - Clears on any I grant.
  - Clears on a D grant made while i_pmem_read = 0.
- **SERVE_x outputs:** pmem_read/pmem_write driven from the latched op, asserted for every cycle until pmem_resp.
- **Response forwarding:** pmem_resp is forwarded combinationally, same cycle, to the granted side only: x_pmem_resp = pmem_resp & grant_x.
- **rdata:** i_pmem_rdata and d_pmem_rdata are both wired to pmem_rdata. Consumers qualify with their own resp.
- **Completion:** on pmem_resp in SERVE_x, go to HOLD. pmem_read/pmem_write drop the cycle after resp.
- **HOLD:** all commands 0 for one cycle, then IDLE. This lets the requester drop its request.
- **Latency:**
  - A request sampled in IDLE at edge N reaches pmem at cycle N+1.
  - Response at cycle M gives earliest next grant at edge M+2; next pmem command at M+3.
- **pmem_resp outside SERVE_x:** ignored, not forwarded, no state change.
- **Request dropped mid-grant:** the transaction still completes downstream; the resp is forwarded regardless.
- **Reset mid-transaction:** abandon immediately, go to IDLE with commands 0 next cycle. A late pmem_resp is ignored.

Test Plan:
1. **Reset:** reset=1 for 2 cycles with both requests high -> all outputs 0, grant_i=grant_d=0; after release, grant_d=1 on the first edge.
2. **Single I read:** i_pmem_read=1, addr 0x1230; pmem_resp after 3 cycles with rdata 0xDEAD..BEEF -> pmem_address=0x1230, i_pmem_resp=1 in the same cycle, d_pmem_resp=0; HOLD for 1 cycle, then IDLE.
3. **Simultaneous requests:** I addr 0x0040 and D write addr 0x8000, wdata 0xA5..A5 -> D served first (pmem_write=1, wdata latched); after HOLD, I served.
4. **Starvation bound:** I held high while D issues 6 back-to-back misses, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D; streak returns to 0 after the I grant.
5. **Latch stability:** change d_pmem_address from 0x8000 to 0x9000 two cycles into SERVE_D -> pmem_address stays 0x8000 until resp.
6. **Reset mid-transaction:** assert reset in SERVE_I before resp, then pulse pmem_resp the next cycle -> IDLE, i_pmem_resp stays 0, pmem_read=0.
